param_shift_reg: RTL and testbench

PARAM_SHIFT_REG -- requirements
Module: param_shift_reg

---
 rtl/shift_reg_pkg.sv | 11 +
 rtl/shift_stage.sv | 38 +++
 rtl/param_shift_reg.sv | 77 +++++++
 tb/tb_param_shift_reg.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the parameterised shift register: the 2-bit mode encodings.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_SHIFT  = 2'b01,
    MODE_ROTATE = 2'b10,
    MODE_LOAD   = 2'b11
  } mode_e;

endpackage

// File: rtl/shift_stage.sv
// One WIDTH-bit stage of the shift register: async-reset register with a
// hold / serial / rotate-source / parallel-load next-value mux.
module shift_stage
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] serial_in,
  input  logic [WIDTH-1:0] rotate_in,
  input  logic [WIDTH-1:0] load_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_next;

  always_comb begin
    q_next = q;
    if (en) begin
      case (mode_e'(mode))
        MODE_SHIFT:  q_next = serial_in;
        MODE_ROTATE: q_next = rotate_in;
        MODE_LOAD:   q_next = load_in;
        default:     q_next = q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= RESET_VAL;
    else       q <= q_next;
  end

endmodule

// File: rtl/param_shift_reg.sv
// Parameterised multi-mode shift register (hold / shift / rotate / load) with a
// saturating count of stages filled since reset. All outputs come from registers.
module param_shift_reg
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic [WIDTH-1:0]           d,
  input  logic [WIDTH*DEPTH-1:0]     load_data,
  output logic [WIDTH-1:0]           dout,
  output logic [WIDTH*DEPTH-1:0]     q,
  output logic [$clog2(DEPTH+1)-1:0] fill_cnt,
  output logic                       full
);

  localparam int           CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [CW-1:0]    fill_cnt_reg;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] serial_src;
      logic [WIDTH-1:0] rotate_src;

      // Stage 0 takes d when shifting and wraps from the last stage when rotating.
      if (gi == 0) begin : g_head
        assign serial_src = d;
        assign rotate_src = stage_q[DEPTH-1];
      end else begin : g_body
        assign serial_src = stage_q[gi-1];
        assign rotate_src = stage_q[gi-1];
      end

      shift_stage #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_stage (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .serial_in (serial_src),
        .rotate_in (rotate_src),
        .load_in   (load_data[gi*WIDTH +: WIDTH]),
        .q         (stage_q[gi])
      );

      assign q[gi*WIDTH +: WIDTH] = stage_q[gi];
    end
  endgenerate

  // Shifts fill one more stage (saturating); a load fills them all; rotate keeps the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_cnt_reg <= '0;
    end else if (en) begin
      case (mode_e'(mode))
        MODE_SHIFT: if (fill_cnt_reg != FULL_CNT) fill_cnt_reg <= fill_cnt_reg + 1'b1;
        MODE_LOAD:  fill_cnt_reg <= FULL_CNT;
        default:    fill_cnt_reg <= fill_cnt_reg;
      endcase
    end
  end

  assign dout     = stage_q[DEPTH-1];
  assign fill_cnt = fill_cnt_reg;
  assign full     = (fill_cnt_reg == FULL_CNT);

endmodule

// File: tb/tb_param_shift_reg.sv
// Directed bench for param_shift_reg: four instances cover serial latency,
// load/rotate, reset-value abort, fill saturation/enable hold and DEPTH=1.
module tb_param_shift_reg;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Instance A: WIDTH=1 DEPTH=2
  logic       rst_a = 1'b0, en_a = 1'b0, d_a = 1'b0;
  logic [1:0] mode_a = 2'b00, ld_a = '0, q_a, fc_a;
  logic       dout_a, full_a;
  param_shift_reg #(.WIDTH(1), .DEPTH(2), .RESET_VAL(1'b0)) u_a (
    .clk(clk), .reset(rst_a), .en(en_a), .mode(mode_a), .d(d_a), .load_data(ld_a),
    .dout(dout_a), .q(q_a), .fill_cnt(fc_a), .full(full_a));

  // Instance B: WIDTH=8 DEPTH=4 RESET_VAL=0
  logic        rst_b = 1'b0, en_b = 1'b0, full_b;
  logic [1:0]  mode_b = 2'b00;
  logic [7:0]  d_b = '0, dout_b;
  logic [31:0] ld_b = '0, q_b;
  logic [2:0]  fc_b;
  param_shift_reg #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u_b (
    .clk(clk), .reset(rst_b), .en(en_b), .mode(mode_b), .d(d_b), .load_data(ld_b),
    .dout(dout_b), .q(q_b), .fill_cnt(fc_b), .full(full_b));

  // Instance C: WIDTH=8 DEPTH=4 RESET_VAL=0xA5
  logic        rst_c = 1'b0, en_c = 1'b0, full_c;
  logic [1:0]  mode_c = 2'b00;
  logic [7:0]  d_c = '0, dout_c;
  logic [31:0] ld_c = '0, q_c;
  logic [2:0]  fc_c;
  param_shift_reg #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) u_c (
    .clk(clk), .reset(rst_c), .en(en_c), .mode(mode_c), .d(d_c), .load_data(ld_c),
    .dout(dout_c), .q(q_c), .fill_cnt(fc_c), .full(full_c));

  // Instance D: WIDTH=4 DEPTH=1
  logic       rst_d = 1'b0, en_d = 1'b0, full_d;
  logic [1:0] mode_d = 2'b00;
  logic [3:0] d_d = '0, ld_d = '0, dout_d, q_d;
  logic [0:0] fc_d;
  param_shift_reg #(.WIDTH(4), .DEPTH(1), .RESET_VAL(4'h0)) u_d (
    .clk(clk), .reset(rst_d), .en(en_d), .mode(mode_d), .d(d_d), .load_data(ld_d),
    .dout(dout_d), .q(q_d), .fill_cnt(fc_d), .full(full_d));

  // Serial input of instance A toggles independently of the clock.
  initial forever #223 d_a = ~d_a;

  initial begin
    logic prev_a, cur_a;
    prev_a = 1'b0;

    #1;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
    #4;
    check("rst_a_q",    32'(q_a),    32'h0);
    check("rst_a_fill", 32'(fc_a),   32'h0);
    check("rst_a_full", 32'(full_a), 32'h0);
    check("rst_c_q",    q_c,         32'hA5A5A5A5);
    check("rst_c_full", 32'(full_c), 32'h0);
    check("rst_d_dout", 32'(dout_d), 32'h0);

    // Release at 147 ns; instance A starts shifting immediately.
    #142;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
    en_a = 1'b1; mode_a = 2'b01;

    // A: dout equals d sampled at the previous enabled edge (2-edge delay).
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk);
      cur_a = d_a;
      #1;
      check($sformatf("a_dout_e%0d", e), 32'(dout_a), 32'(prev_a));
      if (e == 1) begin
        check("a_fill_e1", 32'(fc_a), 32'h1);
        check("a_full_e1", 32'(full_a), 32'h0);
      end
      if (e == 2) begin
        check("a_fill_e2", 32'(fc_a), 32'h2);
        check("a_full_e2", 32'(full_a), 32'h1);
      end
      if (e == 10) check("a_fill_sat", 32'(fc_a), 32'h2);
      prev_a = cur_a;
    end
    en_a = 1'b0;

    // B: parallel load then four rotates.
    en_b = 1'b1; mode_b = 2'b11; ld_b = 32'h44332211;
    @(posedge clk); #1;
    check("b_load_q",    q_b,         32'h44332211);
    check("b_load_dout", 32'(dout_b), 32'h44);
    check("b_load_fill", 32'(fc_b),   32'h4);
    check("b_load_full", 32'(full_b), 32'h1);
    mode_b = 2'b10;
    @(posedge clk); #1;
    check("b_rot1_q",    q_b,         32'h33221144);
    check("b_rot1_dout", 32'(dout_b), 32'h33);
    @(posedge clk); #1;
    check("b_rot2_q",    q_b,         32'h22114433);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("b_rot4_q",    q_b,         32'h44332211);
    check("b_rot4_fill", 32'(fc_b),   32'h4);
    mode_b = 2'b00; d_b = 8'hEE;
    @(posedge clk); #1;
    check("b_hold_q",    q_b,         32'h44332211);

    // B: reset, then six shifts saturate fill_cnt at 4.
    rst_b = 1'b1; #1;
    check("b_rst_q",    q_b,         32'h0);
    check("b_rst_fill", 32'(fc_b),   32'h0);
    check("b_rst_full", 32'(full_b), 32'h0);
    rst_b = 1'b0; mode_b = 2'b01;
    for (int i = 0; i < 6; i++) begin
      d_b = 8'(8'h10 + i);
      @(posedge clk); #1;
      check($sformatf("b_fill_s%0d", i + 1), 32'(fc_b), (i < 4) ? 32'(i + 1) : 32'h4);
      if (i == 3) check("b_latency_dout", 32'(dout_b), 32'h10);
    end
    check("b_shift6_q",    q_b,         32'h12131415);
    check("b_shift6_full", 32'(full_b), 32'h1);
    en_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d_b = 8'(8'h80 + i);
      @(posedge clk); #1;
      check($sformatf("b_en0_q%0d", i), q_b, 32'h12131415);
    end
    check("b_en0_fill", 32'(fc_b), 32'h4);

    // C: shift 0x01, 0x02, then reset between edges.
    en_c = 1'b1; mode_c = 2'b01; d_c = 8'h01;
    @(posedge clk); #1;
    check("c_s1_q", q_c, 32'hA5A5A501);
    d_c = 8'h02;
    @(posedge clk); #1;
    check("c_s2_q",    q_c,       32'hA5A501_02);
    check("c_s2_fill", 32'(fc_c), 32'h2);
    #5 rst_c = 1'b1; #1;
    check("c_rst_q",    q_c,         32'hA5A5A5A5);
    check("c_rst_fill", 32'(fc_c),   32'h0);
    check("c_rst_full", 32'(full_c), 32'h0);
    #4 rst_c = 1'b0; d_c = 8'h03;
    @(posedge clk); #1;
    check("c_post_q",    q_c,       32'hA5A5A503);
    check("c_post_fill", 32'(fc_c), 32'h1);
    en_c = 1'b0;

    // D: DEPTH=1 shift, rotate, shift.
    en_d = 1'b1; mode_d = 2'b01; d_d = 4'h9;
    @(posedge clk); #1;
    check("d_shift_dout", 32'(dout_d), 32'h9);
    check("d_shift_full", 32'(full_d), 32'h1);
    mode_d = 2'b10; d_d = 4'h3;
    @(posedge clk); #1;
    check("d_rot_dout", 32'(dout_d), 32'h9);
    mode_d = 2'b01;
    @(posedge clk); #1;
    check("d_shift2_dout", 32'(dout_d), 32'h3);
    check("d_fill", 32'(fc_d), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
